// File: rtl/ad1_pkg.sv
// ad1_pkg: shared constants and state encoding
// for the Pmod AD1 dual-channel ADC reader.
package ad1_pkg;

  localparam int FRAME_BITS = 16;
  localparam int LEAD_BITS  = 4;
  localparam int DATA_BITS  = 12;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE,
    QUIET
  } state_t;

endpackage

// File: rtl/ad1_sclk_gen.sv
// ad1_sclk_gen: half-period divider producing SCLK
// plus fall/rise enables for the frame sequencer.
module ad1_sclk_gen
  import ad1_pkg::*;
#(
  parameter int HALF_PERIOD = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_fall_tick,
  output logic o_rise_tick,
  output logic o_sclk
);

  localparam int CW = $clog2(HALF_PERIOD) + 1;
  localparam logic [CW-1:0] LAST =
    CW'(HALF_PERIOD - 1);

  logic [CW-1:0] r_cnt;
  logic          r_sclk;
  logic          w_tick;

  assign w_tick      = i_en && (r_cnt == LAST);
  assign o_fall_tick = w_tick && r_sclk;
  assign o_rise_tick = w_tick && !r_sclk;
  assign o_sclk      = r_sclk;

  // half-period counter, parked at zero when idle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // SCLK toggles per tick and idles high
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclk <= 1'b1;
    end else if (!i_en) begin
      r_sclk <= 1'b1;
    end else if (w_tick) begin
      r_sclk <= !r_sclk;
    end
  end

endmodule

// File: rtl/ad1_dual.sv
// ad1_dual: reads one 16-bit frame from each of two
// AD7476A ADCs in parallel and presents 12-bit samples.
module ad1_dual
  import ad1_pkg::*;
#(
  parameter int HALF_PERIOD  = 4,
  parameter int QUIET_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           SDATA,
  output logic                 CS,
  output logic                 SCLK,
  output logic                 busy,
  output logic                 valid,
  output logic [DATA_BITS-1:0] data0,
  output logic [DATA_BITS-1:0] data1,
  output logic                 frame_err
);

  localparam int QW = $clog2(QUIET_CYCLES) + 1;
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [QW-1:0] QLAST =
    QW'(QUIET_CYCLES - 1);

  state_t r_state;
  state_t w_next;

  logic [FRAME_BITS-1:0] r_sr0;
  logic [FRAME_BITS-1:0] r_sr1;
  logic [BW-1:0]         r_bit;
  logic [QW-1:0]         r_qcnt;
  logic                  r_cs;
  logic                  r_busy;
  logic                  r_valid;
  logic [DATA_BITS-1:0]  r_d0;
  logic [DATA_BITS-1:0]  r_d1;
  logic                  r_err;

  logic w_en;
  logic w_fall;
  logic w_rise;
  logic w_q_done;
  logic w_accept;

  assign w_en = (r_state == SETUP) ||
                (r_state == SHIFT);
  assign w_q_done = (r_state == QUIET) &&
                    (r_qcnt == QLAST);
  assign w_accept = (r_state == IDLE) && start;

  ad1_sclk_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_sclk (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_en       (w_en),
    .o_fall_tick(w_fall),
    .o_rise_tick(w_rise),
    .o_sclk     (SCLK)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next state: the final rise follows the wrap of
  // the bit counter after the 16th sample
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (start) w_next = SETUP;
      SETUP: if (w_fall) w_next = SHIFT;
      SHIFT: if (w_rise && (r_bit == '0))
               w_next = DONE;
      DONE:  w_next = QUIET;
      QUIET: if (w_q_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // CS and busy; busy stays up across
  // back-to-back frames while start is held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cs   <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      if (r_state == IDLE) r_busy <= start;
      if (w_accept) r_cs <= 1'b0;
      if (r_state == DONE) r_cs <= 1'b1;
      if (w_q_done) r_busy <= start;
    end
  end

  // shift in both channels on each SCLK fall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr0 <= '0;
      r_sr1 <= '0;
      r_bit <= '0;
    end else if (w_accept) begin
      r_bit <= '0;
    end else if (w_fall) begin
      r_sr0 <= {r_sr0[FRAME_BITS-2:0], SDATA[0]};
      r_sr1 <= {r_sr1[FRAME_BITS-2:0], SDATA[1]};
      r_bit <= r_bit + BW'(1);
    end
  end

  // quiet-time counter between frames
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_qcnt <= '0;
    end else if (w_q_done || (r_state != QUIET)) begin
      r_qcnt <= '0;
    end else begin
      r_qcnt <= r_qcnt + QW'(1);
    end
  end

  // publish samples and lead-bit error at frame end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_d0    <= '0;
      r_d1    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= (r_state == DONE);
      if (r_state == DONE) begin
        r_d0  <= r_sr0[DATA_BITS-1:0];
        r_d1  <= r_sr1[DATA_BITS-1:0];
        r_err <=
          (|r_sr0[FRAME_BITS-1 -: LEAD_BITS]) |
          (|r_sr1[FRAME_BITS-1 -: LEAD_BITS]);
      end
    end
  end

  assign CS        = r_cs;
  assign busy      = r_busy;
  assign valid     = r_valid;
  assign data0     = r_d0;
  assign data1     = r_d1;
  assign frame_err = r_err;

endmodule

// File: tb/tb_ad1_dual.sv
// tb_ad1_dual: two instances (default and fastest
// divider) driven by an AD7476A-style serial source.
module tb_ad1_dual;

  localparam int H0 = 4;
  localparam int Q0 = 4;
  localparam int H1 = 1;
  localparam int Q1 = 1;

  typedef struct packed {
    logic [11:0] a;
    logic [11:0] b;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn [2];
  logic        st   [2];
  logic [1:0]  sd   [2];
  logic        cs   [2];
  logic        sclk [2];
  logic        busy [2];
  logic        valid[2];
  logic        err  [2];
  logic [11:0] d0   [2];
  logic [11:0] d1   [2];
  logic [15:0] w0   [2];
  logic [15:0] w1   [2];

  exp_t qa[$];
  exp_t qb[$];

  int ncmp = 0;
  int nerr = 0;
  int cyc  = 0;

  int   idx  [2] = '{-1, -1};
  int   falls[2] = '{0, 0};
  int   t0   [2] = '{0, 0};
  int   trise[2] = '{0, 0};
  int   lastf[2] = '{-1, -1};
  logic pcs  [2] = '{1'b1, 1'b1};
  logic psclk[2] = '{1'b1, 1'b1};
  logic pval [2] = '{1'b0, 1'b0};
  logic chk_busy[2] = '{1'b0, 1'b0};
  logic chk_gap [2] = '{1'b0, 1'b0};

  ad1_dual #(
    .HALF_PERIOD(H0), .QUIET_CYCLES(Q0)
  ) u_a (
    .clk(clk), .rst(rstn[0]), .start(st[0]),
    .SDATA(sd[0]), .CS(cs[0]), .SCLK(sclk[0]),
    .busy(busy[0]), .valid(valid[0]),
    .data0(d0[0]), .data1(d1[0]),
    .frame_err(err[0])
  );

  ad1_dual #(
    .HALF_PERIOD(H1), .QUIET_CYCLES(Q1)
  ) u_b (
    .clk(clk), .rst(rstn[1]), .start(st[1]),
    .SDATA(sd[1]), .CS(cs[1]), .SCLK(sclk[1]),
    .busy(busy[1]), .valid(valid[1]),
    .data0(d0[1]), .data1(d1[1]),
    .frame_err(err[1])
  );

  function automatic int hp(input int g);
    return (g == 0) ? H0 : H1;
  endfunction

  function automatic int qc(input int g);
    return (g == 0) ? Q0 : Q1;
  endfunction

  task automatic chk(input string nm, input int g,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp = ncmp + 1;
    if (act !== exp) begin
      nerr = nerr + 1;
      $display("FAIL %s[%0d]: got %0h expected %0h",
               nm, g, act, exp);
    end
  endtask

  // ADC source plus per-cycle output checks
  always @(negedge clk) begin
    exp_t x;
    int   qs;
    cyc = cyc + 1;
    for (int g = 0; g < 2; g++) begin
      if (pcs[g] != cs[g])
        chk("sclk_high_at_cs_edge", g, sclk[g], 1);
      if (pcs[g] && !cs[g]) begin
        idx[g]   = 15;
        falls[g] = 0;
        lastf[g] = -1;
        t0[g]    = cyc;
        if (chk_gap[g])
          chk("cs_gap", g, cyc - trise[g], qc(g) + 1);
      end
      if (!pcs[g] && cs[g]) trise[g] = cyc;
      if (!cs[g] && psclk[g] && !sclk[g]) begin
        idx[g]   = idx[g] - 1;
        falls[g] = falls[g] + 1;
        if (lastf[g] >= 0)
          chk("sclk_period", g, cyc - lastf[g],
              2 * hp(g));
        lastf[g] = cyc;
      end
      if (idx[g] >= 0)
        sd[g] = {w1[g][idx[g]], w0[g][idx[g]]};
      else
        sd[g] = 2'b00;
      if (valid[g]) begin
        chk("valid_one_clk", g, pval[g], 0);
        qs = (g == 0) ? qa.size() : qb.size();
        if (qs == 0) begin
          ncmp = ncmp + 1;
          nerr = nerr + 1;
          $display("FAIL unexpected_valid[%0d]: got 1 expected 0", g);
        end else begin
          x = (g == 0) ? qa.pop_front()
                       : qb.pop_front();
          chk("data0", g, d0[g], x.a);
          chk("data1", g, d1[g], x.b);
          chk("frame_err", g, err[g], x.e);
          chk("latency", g, cyc - t0[g],
              32 * hp(g) + 1);
          chk("sclk_falls", g, falls[g], 16);
        end
      end
      if (chk_busy[g]) chk("busy_held", g, busy[g], 1);
      pcs[g]   = cs[g];
      psclk[g] = sclk[g];
      pval[g]  = valid[g];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setw(input int g,
                      input logic [15:0] a,
                      input logic [15:0] b);
    w0[g] = a;
    w1[g] = b;
  endtask

  task automatic pushx(input int g,
                       input logic [15:0] a,
                       input logic [15:0] b);
    exp_t x;
    x.a = a[11:0];
    x.b = b[11:0];
    x.e = (a[15:12] != 4'd0) || (b[15:12] != 4'd0);
    if (g == 0) qa.push_back(x);
    else        qb.push_back(x);
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    while (busy[g] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (busy[g]) begin
      ncmp = ncmp + 1;
      nerr = nerr + 1;
      $display("FAIL wait_idle[%0d]: busy stuck high", g);
    end
  endtask

  task automatic pulse(input int g);
    wait_idle(g);
    st[g] = 1'b1;
    @(negedge clk);
    st[g] = 1'b0;
  endtask

  task automatic wait_valid(input int g,
                            input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid[g] && n < budget);
    if (!valid[g]) begin
      ncmp = ncmp + 1;
      nerr = nerr + 1;
      $display("FAIL wait_valid[%0d]: no valid in %0d clks",
               g, budget);
    end
  endtask

  initial begin
    int n;
    rstn = '{1'b0, 1'b0};
    st   = '{1'b1, 1'b1};
    setw(0, 16'h0000, 16'h0000);
    setw(1, 16'h0000, 16'h0000);

    // reset held with start high
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        chk("rst_cs", g, cs[g], 1);
        chk("rst_sclk", g, sclk[g], 1);
      end
    end
    chk("rst_busy", 0, busy[0], 0);
    chk("rst_valid", 0, valid[0], 0);
    chk("rst_data0", 0, d0[0], 12'h000);
    chk("rst_data1", 0, d1[0], 12'h000);
    chk("rst_err", 0, err[0], 0);
    st   = '{1'b0, 1'b0};
    rstn = '{1'b1, 1'b1};
    tick(2);

    // single conversion
    setw(0, 16'h0A5C, 16'h03F1);
    pushx(0, 16'h0A5C, 16'h03F1);
    pulse(0);
    wait_valid(0, 200);
    chk("pin_data0", 0, d0[0], 12'hA5C);
    chk("pin_data1", 0, d1[0], 12'h3F1);
    chk("pin_err", 0, err[0], 0);
    chk("busy_in_done", 0, busy[0], 1);
    tick(Q0 - 1);
    chk("busy_quiet_end", 0, busy[0], 1);
    tick(1);
    chk("busy_idle", 0, busy[0], 0);

    // leading-bit error, then a clean frame
    setw(0, 16'h0456, 16'h4123);
    pushx(0, 16'h0456, 16'h4123);
    pulse(0);
    wait_valid(0, 200);
    chk("pin_err_set", 0, err[0], 1);
    chk("pin_err_data1", 0, d1[0], 12'h123);
    setw(0, 16'h0789, 16'h0ABC);
    pushx(0, 16'h0789, 16'h0ABC);
    pulse(0);
    wait_valid(0, 200);
    chk("pin_err_clear", 0, err[0], 0);

    // continuous frames with start held
    wait_idle(0);
    setw(0, 16'h0001, 16'h0FFE);
    pushx(0, 16'h0001, 16'h0FFE);
    pushx(0, 16'h0800, 16'h07FF);
    pushx(0, 16'h0FFF, 16'h0000);
    st[0] = 1'b1;
    wait_valid(0, 200);
    chk_busy[0] = 1'b1;
    chk_gap[0]  = 1'b1;
    setw(0, 16'h0800, 16'h07FF);
    wait_valid(0, 200);
    setw(0, 16'h0FFF, 16'h0000);
    tick(Q0 + 2);
    st[0] = 1'b0;
    wait_valid(0, 200);
    chk("pin_cont_data0", 0, d0[0], 12'hFFF);
    chk_busy[0] = 1'b0;
    chk_gap[0]  = 1'b0;

    // abort mid-frame at the 7th SCLK fall
    setw(0, 16'h0123, 16'h0321);
    pulse(0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(falls[0] == 7 && !cs[0]) && n < 200);
    chk("abort_reached", 0, falls[0], 7);
    rstn[0] = 1'b0;
    #1;
    chk("abort_cs", 0, cs[0], 1);
    chk("abort_sclk", 0, sclk[0], 1);
    chk("abort_busy", 0, busy[0], 0);
    tick(3);
    chk("abort_valid", 0, valid[0], 0);
    chk("abort_data0", 0, d0[0], 12'h000);
    rstn[0] = 1'b1;
    tick(2);
    setw(0, 16'h05A5, 16'h0A5A);
    pushx(0, 16'h05A5, 16'h0A5A);
    pulse(0);
    wait_valid(0, 200);
    chk("pin_after_abort", 0, d0[0], 12'h5A5);

    // fastest divider instance
    setw(1, 16'h0FFF, 16'h0000);
    pushx(1, 16'h0FFF, 16'h0000);
    pulse(1);
    wait_valid(1, 100);
    chk("pin_fast_data0", 1, d0[1], 12'hFFF);
    chk("pin_fast_data1", 1, d1[1], 12'h000);

    tick(10);
    chk("queue_a_drained", 0, qa.size(), 0);
    chk("queue_b_drained", 1, qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
